updi_phy: RTL and testbench
===========================

Name: updi_phy

Overview:
- Single-wire, half-duplex UPDI UART physical layer.
- Sits directly downstream of the UPDI instruction interface:
  - drains that block's TX byte FIFO onto the pin;
  - writes received bytes into its RX byte FIFO.
- Also generates the UPDI BREAK condition used for link reset/recovery.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (>=4).
- BREAK_CLKS, 4096, clk cycles the line is held low for a BREAK.
- CNT_BITS, $clog2(BREAK_CLKS+1), width of the shared cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- tx_fifo_data  in  8  TX FIFO read data; valid the cycle after tx_fifo_rd_en
- tx_fifo_rd_en  out  1  one-cycle pop of TX FIFO
- tx_fifo_empty  in  1  TX FIFO empty
- rx_fifo_data  out  8  received byte
- rx_fifo_wr_en  out  1  one-cycle push into RX FIFO
- rx_fifo_full  in  1  RX FIFO full
- updi_in  in  1  raw pin level (asynchronous)
- updi_oe  out  1  1 = drive pin low; 0 = release (pulled high)
- break_req  in  1  request BREAK; sampled only in IDLE
- break_done  out  1  one-cycle pulse at end of BREAK
- busy  out  1  state != IDLE
- parity_error  out  1  one-cycle pulse, RX parity mismatch
- frame_error  out  1  one-cycle pulse, RX stop bit low
- overrun_error  out  1  one-cycle pulse, RX byte dropped because FIFO full

Behaviour:
- Reset values (asynchronous, rst=0):
  - all outputs 0, state IDLE, counters 0;
  - synchroniser flops reset to 1 (line idle).
- updi_in passes through a 2-flop synchroniser; all RX logic uses the synchronised level.
- Frame format: start(0), 8 data LSB first, even parity (XOR of data), 2 stop(1). 12 bit-times total.
- States: IDLE, TX_FETCH, TX_BITS, RX_BITS, BREAK.
- IDLE priority, highest first:
  1. synchronised falling edge -> RX_BITS;
  2. break_req -> BREAK;
  3. !tx_fifo_empty -> TX_FETCH.
- TX_FETCH:
  - tx_fifo_rd_en=1 for exactly one cycle;
  - next cycle latch {parity,data} into shift register, go TX_BITS.
- TX_BITS:
  - each bit held exactly CLKS_PER_BIT cycles;
  - updi_oe = ~current_bit;
  - after 12th bit -> IDLE.
  - Back-to-back bytes: 2 cycles of idle line (IDLE + fetch) between stop and next start.
  - RX is disabled throughout TX, so the pin echo is ignored.
- RX_BITS:
  - Sample at mid-bit: CLKS_PER_BIT/2 cycles after the detected edge, then every CLKS_PER_BIT.
  - Start sample high -> false start, return IDLE with no outputs.
  - Capture 8 data bits and the parity bit, then sample stop1.
  - Byte end, decided at the stop1 sample, mutually exclusive, priority in this order:
    - stop1 low -> frame_error pulse, byte dropped;
    - else parity mismatch -> parity_error pulse, byte dropped;
    - else rx_fifo_full -> overrun_error pulse, byte dropped;
    - else rx_fifo_wr_en pulse with rx_fifo_data.
  - Then wait for the line high (end of stop2 / BREAK tail) before IDLE. Stop2 is not checked.
  - rx_fifo_data holds its last value between pushes.
- BREAK:
  - updi_oe=1 for BREAK_CLKS cycles;
  - then release;
  - then wait one CLKS_PER_BIT with the line released;
  - break_done pulse, -> IDLE.
  - break_req while not IDLE is ignored (not queued).
- A single counter serves bit timing and BREAK. Counter wrap never occurs: reload on every bit.
- Reset mid-frame: pin released immediately (updi_oe=0 asynchronously); any partial byte discarded; no FIFO pop/push.
- tx_fifo_rd_en is never asserted while tx_fifo_empty=1.

Decomposition:
- Shared package updi_pkg:
  - UPDI_SYNC (8'h55), UPDI_ACK (8'h40);
  - frame constants FRAME_BITS=12, DATA_BITS=8;
  - phy state enum updi_phy_state.
- One natural sub-module: updi_bit_timer. Loadable down-counter with mid-bit/full-bit tick outputs, shared by TX, RX and BREAK.

Test Plan (all with CLKS_PER_BIT=4, BREAK_CLKS=64):
- TX single byte: FIFO holds 8'h55, updi_in looped from ~updi_oe -> exactly one tx_fifo_rd_en; line sequence 0,1,0,1,0,1,0,1,0,0(parity),1,1 at 4 clk/bit; busy high 49 cycles; no rx_fifo_wr_en (echo ignored).
- TX back-to-back 8'h55, 8'h45 -> two frames; second start bit begins 2 cycles after first stop2 ends; parity bits 0 and 1.
- RX byte: drive frame for 8'h40 with parity 1 -> one rx_fifo_wr_en with rx_fifo_data=8'h40; no error pulses.
- RX errors:
  - 8'h40 with parity 0 -> parity_error, no push;
  - stop1=0 -> frame_error, no push;
  - valid byte with rx_fifo_full=1 -> overrun_error, no push;
  - 2-cycle low glitch -> no outputs.
- BREAK: break_req in IDLE -> updi_oe=1 for 64 cycles, released 4 cycles, break_done pulse; break_req during TX -> ignored.
- Reset mid-TX: assert rst during data bit 3 -> updi_oe=0 same cycle; after release, IDLE; the next FIFO byte is transmitted whole.

Source files
------------

// File: rtl/updi_pkg.sv
// updi_pkg: shared UPDI constants and the PHY state encoding.
package updi_pkg;
  localparam logic [7:0] UPDI_SYNC = 8'h55;
  localparam logic [7:0] UPDI_ACK = 8'h40;
  localparam int FRAME_BITS = 12;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    PHY_IDLE,
    PHY_TX_FETCH,
    PHY_TX_BITS,
    PHY_RX_BITS,
    PHY_BREAK
  } updi_phy_state;
endpackage

// File: rtl/updi_bit_timer.sv
// updi_bit_timer: loadable down-counter giving mid-bit, full-bit and BREAK intervals.
module updi_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_CLKS = 4096,
  parameter int CNT_BITS = $clog2(BREAK_CLKS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_mid,
  input  logic load_bit,
  input  logic load_break,
  output logic tick
);
  logic [CNT_BITS-1:0] cnt;
  // Holds at zero rather than wrapping; every interval starts from a reload.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= load_break ? CNT_BITS'(BREAK_CLKS - 1) :
                load_bit   ? CNT_BITS'(CLKS_PER_BIT - 1) :
                load_mid   ? CNT_BITS'(CLKS_PER_BIT / 2 - 1) :
                (cnt == '0) ? cnt : cnt - 1'b1;
  assign tick = cnt == '0;
endmodule

// File: rtl/updi_phy.sv
// updi_phy: half-duplex single-wire UPDI UART PHY with BREAK generation.
module updi_phy
  import updi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_CLKS = 4096,
  parameter int CNT_BITS = $clog2(BREAK_CLKS + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_fifo_data,
  output logic       tx_fifo_rd_en,
  input  logic       tx_fifo_empty,
  output logic [7:0] rx_fifo_data,
  output logic       rx_fifo_wr_en,
  input  logic       rx_fifo_full,
  input  logic       updi_in,
  output logic       updi_oe,
  input  logic       break_req,
  output logic       break_done,
  output logic       busy,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun_error
);
  localparam logic [3:0] PAR_IDX = 4'(DATA_BITS + 1);
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 2);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

  updi_phy_state state, state_nxt;
  logic [1:0] sync_q;
  logic line, line_prev, fall;
  logic [3:0] bit_idx;
  logic [11:0] tx_frame;
  logic tx_load;
  logic [7:0] rx_shift;
  logic rx_par;
  logic tick, load_mid, load_bit, load_break, adv, done, stop_samp, par_ok;

  updi_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .BREAK_CLKS(BREAK_CLKS),
    .CNT_BITS(CNT_BITS)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .load_mid(load_mid),
    .load_bit(load_bit),
    .load_break(load_break),
    .tick(tick)
  );

  assign line = sync_q[1];
  assign fall = line_prev && !line;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= 2'b11;
      line_prev <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], updi_in};
      line_prev <= line;
    end

  // Idx LAST in RX is the wait-for-high phase; in BREAK idx[0] marks the released tail.
  always_comb begin
    load_mid = state == PHY_IDLE && fall;
    load_break = state == PHY_IDLE && !fall && break_req;
    load_bit = state == PHY_TX_FETCH ||
               (tick && state == PHY_TX_BITS && bit_idx != LAST_IDX) ||
               (tick && state == PHY_RX_BITS && bit_idx != LAST_IDX && !(bit_idx == '0 && line)) ||
               (tick && state == PHY_BREAK && !bit_idx[0]);
    adv = load_bit && state != PHY_TX_FETCH;
    done = tick && ((state == PHY_TX_BITS && bit_idx == LAST_IDX) ||
                    (state == PHY_RX_BITS && line && (bit_idx == '0 || bit_idx == LAST_IDX)) ||
                    (state == PHY_BREAK && bit_idx[0]));
    stop_samp = state == PHY_RX_BITS && tick && bit_idx == STOP_IDX;
    par_ok = rx_par == ^rx_shift;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= PHY_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (state == PHY_IDLE)
      state_nxt = fall ? PHY_RX_BITS : break_req ? PHY_BREAK :
                  !tx_fifo_empty ? PHY_TX_FETCH : PHY_IDLE;
    else if (state == PHY_TX_FETCH) state_nxt = PHY_TX_BITS;
    else if (done) state_nxt = PHY_IDLE;
  end

  always_comb begin
    tx_fifo_rd_en = state == PHY_TX_FETCH;
    updi_oe = (state == PHY_TX_BITS && (bit_idx == '0 || !tx_frame[bit_idx])) ||
              (state == PHY_BREAK && !bit_idx[0]);
    break_done = state == PHY_BREAK && tick && bit_idx[0];
    busy = state != PHY_IDLE;
  end

  // FIFO data arrives during the start bit, so the frame is latched then.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bit_idx <= '0;
      tx_load <= 1'b0;
      tx_frame <= '1;
      rx_shift <= '0;
      rx_par <= 1'b0;
    end else begin
      bit_idx <= state == PHY_IDLE ? 4'd0 : adv ? bit_idx + 4'd1 : bit_idx;
      tx_load <= state == PHY_TX_FETCH;
      if (tx_load) tx_frame <= {2'b11, ^tx_fifo_data, tx_fifo_data, 1'b0};
      if (state == PHY_RX_BITS && tick && bit_idx != '0 && bit_idx < PAR_IDX)
        rx_shift <= {line, rx_shift[7:1]};
      if (state == PHY_RX_BITS && tick && bit_idx == PAR_IDX) rx_par <= line;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      frame_error <= 1'b0;
      parity_error <= 1'b0;
      overrun_error <= 1'b0;
      rx_fifo_wr_en <= 1'b0;
      rx_fifo_data <= '0;
    end else begin
      frame_error <= stop_samp && !line;
      parity_error <= stop_samp && line && !par_ok;
      overrun_error <= stop_samp && line && par_ok && rx_fifo_full;
      rx_fifo_wr_en <= stop_samp && line && par_ok && !rx_fifo_full;
      if (stop_samp && line && par_ok && !rx_fifo_full) rx_fifo_data <= rx_shift;
    end
endmodule

// File: tb/tb_updi_phy.sv
// tb_updi_phy: directed scoreboard bench for the UPDI PHY at 4 clk/bit, 64 clk BREAK.
module tb_updi_phy;
  import updi_pkg::*;
  localparam int P = 4;
  localparam int BK = 64;

  logic clk = 0, rst = 0;
  logic [7:0] tx_fifo_data = '0;
  logic tx_fifo_rd_en, tx_fifo_empty;
  logic [7:0] rx_fifo_data;
  logic rx_fifo_wr_en, rx_fifo_full = 0;
  logic updi_in, updi_oe, break_req = 0, break_done, busy;
  logic parity_error, frame_error, overrun_error;
  logic host_line = 1, loop = 0;

  updi_phy #(.CLKS_PER_BIT(P), .BREAK_CLKS(BK)) dut (
    .clk(clk), .rst(rst),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_rd_en(tx_fifo_rd_en), .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_wr_en(rx_fifo_wr_en), .rx_fifo_full(rx_fifo_full),
    .updi_in(updi_in), .updi_oe(updi_oe),
    .break_req(break_req), .break_done(break_done), .busy(busy),
    .parity_error(parity_error), .frame_error(frame_error), .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;
  assign updi_in = loop ? ~updi_oe : host_line;

  logic [7:0] tx_mem [0:63];
  int wp = 0, rp = 0;
  assign tx_fifo_empty = wp == rp;
  always @(posedge clk)
    if (tx_fifo_rd_en) begin
      tx_fifo_data <= tx_mem[rp];
      rp <= rp + 1;
    end

  int cyc = 0, busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  int oerr_cnt = 0, bdone_cnt = 0, oe_cnt = 0, bad_rd = 0;
  logic [7:0] rx_obs[$];
  logic [11:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (tx_fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_fifo_rd_en && tx_fifo_empty) bad_rd <= bad_rd + 1;
    if (rx_fifo_wr_en) wr_cnt <= wr_cnt + 1;
    if (parity_error) perr_cnt <= perr_cnt + 1;
    if (frame_error) ferr_cnt <= ferr_cnt + 1;
    if (overrun_error) oerr_cnt <= oerr_cnt + 1;
    if (break_done) bdone_cnt <= bdone_cnt + 1;
    if (updi_oe) oe_cnt <= oe_cnt + 1;
    if (rx_fifo_wr_en) rx_obs.push_back(rx_fifo_data);
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] b, input bit expect_frame);
    tx_mem[wp] = b;
    wp++;
    if (expect_frame) exp_tx.push_back({2'b11, ^b, b, 1'b0});
  endtask

  task automatic wait_oe(output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = updi_oe;
    end
    if (!ok) chk("tx_start_seen", 0, 1);
  endtask

  task automatic tx_frame(input string tag, output int t0);
    logic [11:0] f;
    bit ok;
    f = '0;
    wait_oe(ok);
    t0 = cyc;
    if (ok) begin
      ticks(P / 2);
      f[0] = ~updi_oe;
      for (int k = 1; k < 12; k++) begin
        ticks(P);
        f[k] = ~updi_oe;
      end
    end
    if (exp_tx.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
    else chk(tag, f, exp_tx.pop_front());
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic s1);
    logic [11:0] f;
    f = {1'b1, s1, par, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      host_line = f[i];
      ticks(P);
    end
    host_line = 1;
    ticks(8);
  endtask

  task automatic rx_pop(input string tag);
    chk({tag, "_count"}, rx_obs.size(), exp_rx.size());
    while (rx_obs.size() > 0 && exp_rx.size() > 0) chk(tag, rx_obs.pop_front(), exp_rx.pop_front());
  endtask

  initial begin
    int t1, t2, b0, r0, w0, e0, hi, rel, d0, o0;
    bit ok, seen;
    ticks(2);
    chk("reset_outputs", {updi_oe, tx_fifo_rd_en, rx_fifo_wr_en, busy, break_done,
                          parity_error, frame_error, overrun_error, rx_fifo_data}, 0);
    rst = 1;
    ticks(4);

    loop = 1;
    b0 = busy_cnt; r0 = rd_cnt; w0 = wr_cnt;
    tx_push(UPDI_SYNC, 1);
    tx_frame("tx_55_frame", t1);
    ticks(10);
    chk("tx_55_pops", rd_cnt - r0, 1);
    chk("tx_55_busy_cycles", busy_cnt - b0, 49);
    chk("tx_55_no_echo_push", wr_cnt - w0, 0);

    r0 = rd_cnt;
    tx_push(8'h55, 1);
    tx_push(8'h45, 1);
    tx_frame("b2b_first", t1);
    tx_frame("b2b_second", t2);
    chk("b2b_start_spacing", t2 - t1, 12 * P + 2);
    ticks(10);
    chk("b2b_pops", rd_cnt - r0, 2);
    loop = 0;

    w0 = wr_cnt; e0 = perr_cnt + ferr_cnt + oerr_cnt;
    exp_rx.push_back(UPDI_ACK);
    send(UPDI_ACK, 1, 1);
    rx_pop("rx_40_data");
    chk("rx_40_push", wr_cnt - w0, 1);
    chk("rx_40_no_err", perr_cnt + ferr_cnt + oerr_cnt - e0, 0);

    w0 = wr_cnt; e0 = perr_cnt;
    send(8'h40, 0, 1);
    chk("rx_parity_err", perr_cnt - e0, 1);
    chk("rx_parity_no_push", wr_cnt - w0, 0);

    w0 = wr_cnt; e0 = ferr_cnt; d0 = perr_cnt;
    send(8'h40, 1, 0);
    chk("rx_frame_err", ferr_cnt - e0, 1);
    chk("rx_frame_no_push_or_perr", (wr_cnt - w0) + (perr_cnt - d0), 0);

    w0 = wr_cnt; e0 = oerr_cnt;
    rx_fifo_full = 1;
    send(8'h3A, 0, 1);
    rx_fifo_full = 0;
    chk("rx_overrun_err", oerr_cnt - e0, 1);
    chk("rx_overrun_no_push", wr_cnt - w0, 0);

    e0 = wr_cnt + perr_cnt + ferr_cnt + oerr_cnt;
    host_line = 0;
    ticks(2);
    host_line = 1;
    ticks(20);
    chk("glitch_no_outputs", wr_cnt + perr_cnt + ferr_cnt + oerr_cnt - e0, 0);
    chk("glitch_idle", busy, 0);
    rx_pop("rx_after_errors");

    d0 = bdone_cnt;
    hi = 0; rel = 0; seen = 0;
    break_req = 1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      break_req = 0;
      if (updi_oe) hi++;
      else if (hi > 0) rel++;
      if (break_done) seen = 1;
    end
    ticks(2);
    chk("break_low_cycles", hi, BK);
    chk("break_release_cycles", rel, P);
    chk("break_done_pulses", bdone_cnt - d0, 1);

    loop = 1;
    d0 = bdone_cnt;
    tx_push(8'h3C, 0);
    wait_oe(ok);
    ticks(10);
    break_req = 1;
    ticks(1);
    break_req = 0;
    for (int i = 0; i < 200 && busy; i++) ticks(1);
    o0 = oe_cnt;
    ticks(BK + 20);
    chk("break_in_tx_ignored", bdone_cnt - d0, 0);
    chk("break_in_tx_no_drive", oe_cnt - o0, 0);

    r0 = rd_cnt;
    tx_push(8'hA5, 0);
    tx_push(UPDI_ACK, 1);
    wait_oe(ok);
    ticks(4 * P + 1);
    rst = 0;
    #1;
    chk("reset_mid_tx_oe", updi_oe, 0);
    chk("reset_mid_tx_busy", busy, 0);
    ticks(3);
    rst = 1;
    tx_frame("tx_after_reset", t1);
    ticks(10);
    chk("reset_tx_pops", rd_cnt - r0, 2);
    chk("no_pop_when_empty", bad_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
